// File: rtl/carriage_pkg.sv
// rtl/carriage_pkg.sv - state encodings, register offsets and bit indices for the carriage sequencer.
package carriage_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_HOMING = 4'd1,
    ST_MOVE   = 4'd2,
    ST_SETTLE = 4'd3,
    ST_FAULT  = 4'd4
  } state_t;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_POS    = 2'd2;

  localparam int CMD_HOME_BIT  = 31;
  localparam int CMD_ABORT_BIT = 30;

  localparam int ST_BUSY_BIT   = 0;
  localparam int ST_HOMED_BIT  = 1;
  localparam int ST_DONE_BIT   = 2;
  localparam int ST_FAULT_BIT  = 3;
  localparam int ST_CMDERR_BIT = 4;
  localparam int ST_WDOG_BIT   = 5;

endpackage

// File: rtl/carriage_step_timer.sv
// rtl/carriage_step_timer.sv - step period counter with clear and enable, ticks every STEP_PERIOD cycles.
module carriage_step_timer #(
  parameter int STEP_PERIOD = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = $clog2(STEP_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(STEP_PERIOD - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/carriage_move_sequencer.sv
// rtl/carriage_move_sequencer.sv - APB home/column sequencer driving stepper strobes for the ball carriage.
// Define MOVE_WDOG_EN to add the per-move step watchdog (STATUS[5]).
module carriage_move_sequencer #(
  parameter int NUM_COLS      = 7,
  parameter int COL0_OFFSET   = 350,
  parameter int COL_PITCH     = 700,
  parameter int MAX_STEPS     = 4900,
  parameter int STEP_PERIOD   = 500000,
  parameter int SETTLE_CYCLES = 2500000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        home_sw,
  input  logic        end_sw,
  output logic        step_pulse,
  output logic        step_dir,
  output logic        busy,
  output logic        irq
);
  import carriage_pkg::*;

  state_t      r_state, w_next;
  logic [31:0] r_pos, r_target, r_settle_cnt, r_prdata;
  logic        r_dir, r_step_pulse, r_homed, r_done, r_fault, r_cmd_err;
  logic        w_wr, w_cmd_wr, w_stat_wr, w_abort, w_home_cmd, w_col_cmd, w_col_ok, w_busy;
  logic        w_tick, w_tmr_clr, w_tmr_en, w_limit;
  logic        w_step, w_set_done, w_set_fault, w_limit_fault, w_home_hit, w_load_move;
  logic        w_set_cmd_err, w_set_wdog, w_wdog_trip, w_wdog_bit;
  logic [31:0] w_target_new, w_status;
  logic        w_unused;

  assign w_wr       = PSEL & PENABLE & PWRITE;
  assign w_cmd_wr   = w_wr & (PADDR[3:2] == REG_CMD);
  assign w_stat_wr  = w_wr & (PADDR[3:2] == REG_STATUS);
  assign w_abort    = w_cmd_wr & PWDATA[CMD_ABORT_BIT];
  assign w_home_cmd = w_cmd_wr & ~PWDATA[CMD_ABORT_BIT] & PWDATA[CMD_HOME_BIT];
  assign w_col_cmd  = w_cmd_wr & ~PWDATA[CMD_ABORT_BIT] & ~PWDATA[CMD_HOME_BIT];
  assign w_col_ok   = {24'd0, PWDATA[7:0]} < 32'(NUM_COLS);
  assign w_target_new = 32'(COL0_OFFSET) + {24'd0, PWDATA[7:0]} * 32'(COL_PITCH);
  assign w_busy     = (r_state == ST_HOMING) || (r_state == ST_MOVE) || (r_state == ST_SETTLE);
  assign w_limit    = r_dir ? end_sw : home_sw;

  assign w_tmr_clr = (w_next != r_state);
  assign w_tmr_en  = (r_state == ST_HOMING) || (r_state == ST_MOVE);

  carriage_step_timer #(.STEP_PERIOD(STEP_PERIOD)) u_step_timer (
    .i_clk   (PCLK),
    .i_rst   (PRESET),
    .i_clear (w_tmr_clr),
    .i_en    (w_tmr_en),
    .o_tick  (w_tick)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Switch checks sit ahead of the tick so a limit hit suppresses a coincident strobe.
  always_comb begin
    w_next        = r_state;
    w_step        = 1'b0;
    w_set_done    = 1'b0;
    w_set_fault   = 1'b0;
    w_limit_fault = 1'b0;
    w_home_hit    = 1'b0;
    w_load_move   = 1'b0;
    w_set_cmd_err = 1'b0;
    w_set_wdog    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_home_cmd) begin
          w_next = ST_HOMING;
        end else if (w_col_cmd) begin
          if (r_homed && w_col_ok) begin
            w_next      = ST_MOVE;
            w_load_move = 1'b1;
          end else begin
            w_set_cmd_err = 1'b1;
          end
        end
      end
      ST_HOMING: begin
        if (w_abort) begin
          w_next = ST_IDLE;
        end else if (home_sw && end_sw) begin
          w_next      = ST_FAULT;
          w_set_fault = 1'b1;
        end else if (home_sw) begin
          w_next     = ST_IDLE;
          w_home_hit = 1'b1;
          w_set_done = 1'b1;
        end else if (w_wdog_trip) begin
          w_next      = ST_FAULT;
          w_set_fault = 1'b1;
          w_set_wdog  = 1'b1;
        end else if (w_tick) begin
          w_step = 1'b1;
        end
      end
      ST_MOVE: begin
        if (w_abort) begin
          w_next = ST_IDLE;
        end else if (w_limit) begin
          w_next        = ST_FAULT;
          w_set_fault   = 1'b1;
          w_limit_fault = 1'b1;
        end else if (w_wdog_trip) begin
          w_next      = ST_FAULT;
          w_set_fault = 1'b1;
          w_set_wdog  = 1'b1;
        end else if (r_pos == r_target) begin
          w_next = ST_SETTLE;
        end else if (w_tick) begin
          w_step = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_abort) begin
          w_next = ST_IDLE;
        end else if (r_settle_cnt == 32'(SETTLE_CYCLES - 1)) begin
          w_next     = ST_IDLE;
          w_set_done = 1'b1;
        end
      end
      ST_FAULT: begin
        if (!r_fault) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if ((r_state != ST_IDLE) && (w_home_cmd || w_col_cmd)) w_set_cmd_err = 1'b1;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_pos        <= '0;
      r_target     <= '0;
      r_settle_cnt <= '0;
      r_dir        <= 1'b0;
      r_step_pulse <= 1'b0;
      r_homed      <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_prdata     <= '0;
    end else begin
      r_step_pulse <= w_step;
      if (w_load_move) begin
        r_target <= w_target_new;
        r_dir    <= (w_target_new > r_pos);
      end else if ((r_state == ST_IDLE) && (w_next == ST_HOMING)) begin
        r_dir <= 1'b0;
      end
      if (w_home_hit)         r_pos <= '0;
      else if (w_limit_fault) r_pos <= r_dir ? 32'(MAX_STEPS) : '0;
      else if (w_step)        r_pos <= r_dir ? r_pos + 32'd1 : ((r_pos == '0) ? '0 : r_pos - 32'd1);
      if (w_tmr_clr)                  r_settle_cnt <= '0;
      else if (r_state == ST_SETTLE)  r_settle_cnt <= r_settle_cnt + 32'd1;
      if (w_home_hit)       r_homed <= 1'b1;
      else if (w_set_fault) r_homed <= 1'b0;
      if (w_set_done)                               r_done <= 1'b1;
      else if (w_stat_wr && PWDATA[ST_DONE_BIT])    r_done <= 1'b0;
      if (w_set_fault)                              r_fault <= 1'b1;
      else if (w_stat_wr && PWDATA[ST_FAULT_BIT])   r_fault <= 1'b0;
      if (w_set_cmd_err)                            r_cmd_err <= 1'b1;
      else if (w_stat_wr && PWDATA[ST_CMDERR_BIT])  r_cmd_err <= 1'b0;
      if (PSEL && !PWRITE) begin
        case (PADDR[3:2])
          REG_STATUS: r_prdata <= w_status;
          REG_POS:    r_prdata <= r_pos;
          default:    r_prdata <= '0;
        endcase
      end
    end
  end

`ifdef MOVE_WDOG_EN
  logic [31:0] r_step_cnt;
  logic        r_wdog;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_step_cnt <= '0;
      r_wdog     <= 1'b0;
    end else begin
      if (w_tmr_clr)   r_step_cnt <= '0;
      else if (w_step) r_step_cnt <= r_step_cnt + 32'd1;
      if (w_set_wdog)                            r_wdog <= 1'b1;
      else if (w_stat_wr && PWDATA[ST_WDOG_BIT]) r_wdog <= 1'b0;
    end
  end

  assign w_wdog_trip = (r_step_cnt > 32'(MAX_STEPS + COL_PITCH));
  assign w_wdog_bit  = r_wdog;
`else
  assign w_wdog_trip = 1'b0;
  assign w_wdog_bit  = 1'b0;
`endif

  assign w_status   = {12'd0, r_state, 10'd0, w_wdog_bit, r_cmd_err, r_fault, r_done, r_homed, w_busy};
  assign w_unused   = ^{PADDR[31:4], PADDR[1:0], PWDATA[29:8]};

  assign PRDATA     = r_prdata;
  assign PREADY     = 1'b1;
  assign PSLVERR    = 1'b0;
  assign step_pulse = r_step_pulse;
  assign step_dir   = r_dir;
  assign busy       = w_busy;
  assign irq        = r_done | r_fault;

endmodule

// File: tb/tb_carriage_move_sequencer.sv
// tb/tb_carriage_move_sequencer.sv - vector table plus strobe scoreboard for carriage_move_sequencer.
module tb_carriage_move_sequencer;

  localparam int SP = 4;
  localparam int SC = 8;
  localparam logic [31:0] A_CMD = 32'h0, A_STAT = 32'h4, A_POS = 32'h8;
  localparam logic [31:0] HOME = 32'h8000_0000, ABORT = 32'h4000_0000;

  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        home_sw = 1'b0, end_sw = 1'b0;
  logic        step_pulse, step_dir, busy, irq;

  typedef struct { logic dir; int gap; } strobe_t;
  typedef struct { logic [7:0] col; int n; logic dir; logic [31:0] pos; logic done; logic err; } vec_t;

  strobe_t exp_q[$];
  vec_t    vecs[5];
  int      n_total = 0, n_bad = 0;
  int      cyc = 0, last_strobe_cyc = 0, idle_cyc = 0;
  logic [31:0] rd;

  carriage_move_sequencer #(
    .NUM_COLS(7), .COL0_OFFSET(5), .COL_PITCH(10), .MAX_STEPS(70),
    .STEP_PERIOD(SP), .SETTLE_CYCLES(SC)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .home_sw(home_sw), .end_sw(end_sw), .step_pulse(step_pulse), .step_dir(step_dir),
    .busy(busy), .irq(irq)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    data = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic push_strobes(input int n, input logic dir);
    for (int i = 0; i < n; i++) exp_q.push_back('{dir, (i == 0) ? 0 : SP});
  endtask

  // Pops one expected strobe per observed step_pulse; stops on strobe count or busy low.
  task automatic watch(input int max_cyc, input int stop_strobes, input bit stop_idle);
    strobe_t e;
    int seen = 0;
    bit stopped = 1'b0;
    for (int i = 0; i < max_cyc && !stopped; i++) begin
      @(negedge PCLK);
      if (step_pulse === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_dir", {31'd0, step_dir}, {31'd0, e.dir});
          if (e.gap > 0) check("strobe_gap", 32'(cyc - last_strobe_cyc), 32'(e.gap));
        end
        last_strobe_cyc = cyc;
        seen++;
        if (stop_strobes > 0 && seen == stop_strobes) stopped = 1'b1;
      end
      if (stop_idle && busy === 1'b0) begin
        stopped  = 1'b1;
        idle_cyc = cyc;
      end
    end
    if ((stop_strobes > 0 || stop_idle) && !stopped) check("watch_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vecs[0] = '{8'd2, 25, 1'b1, 32'd25, 1'b1, 1'b0};
    vecs[1] = '{8'd0, 20, 1'b0, 32'd5,  1'b1, 1'b0};
    vecs[2] = '{8'd9, 0,  1'b0, 32'd5,  1'b0, 1'b1};
    vecs[3] = '{8'd0, 0,  1'b0, 32'd5,  1'b1, 1'b0};
    vecs[4] = '{8'd1, 10, 1'b1, 32'd15, 1'b1, 1'b0};

    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    check("rst_step_pulse", {31'd0, step_pulse}, 32'd0);
    check("rst_step_dir", {31'd0, step_dir}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("pready", {31'd0, PREADY}, 32'd1);
    check("pslverr", {31'd0, PSLVERR}, 32'd0);
    apb_read(A_STAT, rd); check("rst_status", rd, 32'd0);
    apb_read(A_POS, rd);  check("rst_pos", rd, 32'd0);

    apb_write(A_CMD, 32'd1);
    watch(10, 0, 1);
    apb_read(A_STAT, rd); check("unhomed_cmd_err", rd, 32'h10);
    apb_write(A_STAT, 32'h3C);

    push_strobes(3, 1'b0);
    apb_write(A_CMD, HOME);
    watch(200, 3, 0);
    home_sw = 1'b1;
    watch(50, 0, 1);
    home_sw = 1'b0;
    check("home_strobes_left", 32'(exp_q.size()), 32'd0);
    apb_read(A_STAT, rd); check("home_status", rd, 32'h6);
    check("home_irq", {31'd0, irq}, 32'd1);
    apb_read(A_POS, rd);  check("home_pos", rd, 32'd0);

    for (int v = 0; v < 5; v++) begin
      apb_write(A_STAT, 32'h3C);
      push_strobes(vecs[v].n, vecs[v].dir);
      apb_write(A_CMD, {24'd0, vecs[v].col});
      watch(1000, 0, 1);
      check("vec_strobes_left", 32'(exp_q.size()), 32'd0);
      if (vecs[v].n > 0) check("vec_settle_len", 32'(idle_cyc - last_strobe_cyc), 32'(SC + 1));
      apb_read(A_STAT, rd);
      check("vec_done", {31'd0, rd[2]}, {31'd0, vecs[v].done});
      check("vec_cmd_err", {31'd0, rd[4]}, {31'd0, vecs[v].err});
      check("vec_state", {28'd0, rd[19:16]}, 32'd0);
      check("vec_irq", {31'd0, irq}, {31'd0, vecs[v].done});
      apb_read(A_POS, rd);
      check("vec_pos", rd, vecs[v].pos);
    end

    apb_write(A_STAT, 32'h3C);
    push_strobes(10, 1'b1);
    apb_write(A_CMD, 32'd6);
    watch(200, 10, 0);
    watch(3, 0, 0);
    end_sw = 1'b1;
    watch(50, 0, 1);
    end_sw = 1'b0;
    check("fault_strobes_left", 32'(exp_q.size()), 32'd0);
    apb_read(A_STAT, rd);
    check("fault_status", rd, 32'h0004_0008);
    check("fault_irq", {31'd0, irq}, 32'd1);
    apb_read(A_POS, rd); check("fault_pos", rd, 32'd70);
    apb_write(A_STAT, 32'h08);
    apb_read(A_STAT, rd); check("fault_cleared", rd, 32'd0);
    apb_write(A_CMD, 32'd1);
    watch(10, 0, 1);
    apb_read(A_STAT, rd); check("post_fault_cmd_err", rd, 32'h10);

    apb_write(A_STAT, 32'h3C);
    home_sw = 1'b1; end_sw = 1'b1;
    apb_write(A_CMD, HOME);
    watch(20, 0, 1);
    home_sw = 1'b0; end_sw = 1'b0;
    apb_read(A_STAT, rd); check("both_sw_fault", rd, 32'h0004_0008);
    apb_write(A_STAT, 32'h3C);

    home_sw = 1'b1;
    apb_write(A_CMD, HOME);
    watch(20, 0, 1);
    home_sw = 1'b0;
    apb_read(A_STAT, rd); check("zero_step_home", rd, 32'h6);
    apb_read(A_POS, rd);  check("zero_step_pos", rd, 32'd0);

    apb_write(A_STAT, 32'h3C);
    push_strobes(5, 1'b1);
    apb_write(A_CMD, 32'd3);
    watch(200, 1, 0);
    apb_write(A_CMD, 32'd5);
    watch(200, 4, 0);
    apb_write(A_CMD, ABORT);
    check("abort_next_cycle", {31'd0, busy}, 32'd0);
    watch(12, 0, 0);
    check("abort_strobes_left", 32'(exp_q.size()), 32'd0);
    apb_read(A_STAT, rd);
    check("abort_status", rd, 32'h12);
    apb_read(A_POS, rd); check("abort_pos", rd, 32'd5);

`ifdef MOVE_WDOG_EN
    apb_write(A_STAT, 32'h3C);
    push_strobes(81, 1'b0);
    apb_write(A_CMD, HOME);
    watch(81 * SP + 40, 0, 1);
    check("wdog_strobes_left", 32'(exp_q.size()), 32'd0);
    apb_read(A_STAT, rd); check("wdog_status", rd, 32'h0004_0028);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
